// File: rtl/cpu_pkg.sv
// Shared widths, reset vector and fetch payload type for the 16-bit core.
package cpu_pkg;

    localparam int unsigned CPU_ADDR_W  = 16;
    localparam int unsigned CPU_INSTR_W = 16;
    localparam logic [CPU_ADDR_W-1:0] CPU_RESET_PC = 16'h0000;

    typedef struct packed {
        logic [CPU_ADDR_W-1:0]  pc;
        logic [CPU_INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous instruction buffer; flush beats push, head data stays visible in the flush cycle.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = CPU_ADDR_W + CPU_INSTR_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  logic [WIDTH-1:0]             wdata,
    output logic [WIDTH-1:0]             rdata,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    always_comb begin
        do_push  = push && (!full || pop);
        do_pop   = pop && !empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Decoupled instruction fetch: credit-limited requests, buffered responses,
// redirect with stale-response squashing, sticky halt.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned       ADDR_W   = CPU_ADDR_W,
    parameter int unsigned       INSTR_W  = CPU_INSTR_W,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(CPU_RESET_PC)
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    input  logic               halt_req,
    output logic               halted
);
    localparam int unsigned CW    = $clog2(DEPTH + 1);
    localparam int unsigned SW    = CW + 1;
    localparam int unsigned WIDTH = ADDR_W + INSTR_W;

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
    logic [CW-1:0]     outstanding_q, outstanding_d;
    logic [CW-1:0]     drop_cnt_q, drop_cnt_d;
    logic              halted_q, halted_d;

    logic              gnt, rsp, rsp_live, pop, push, flush;
    logic [CW-1:0]     fifo_count;
    logic [WIDTH-1:0]  fifo_rdata;
    logic              fifo_full, fifo_empty;

    // Credit check covers both in-flight requests and buffered entries, so the FIFO cannot overflow.
    assign imem_req  = !rst && !halted_q &&
                       ((SW'(outstanding_q) + SW'(fifo_count)) < SW'(DEPTH));
    assign imem_addr = fetch_pc_q;
    assign out_valid = !fifo_empty;
    assign out_pc    = fifo_rdata[WIDTH-1 -: ADDR_W];
    assign out_instr = fifo_rdata[INSTR_W-1:0];
    assign halted    = halted_q;

    assign gnt      = imem_req && imem_gnt;
    assign rsp      = imem_rvalid && (outstanding_q != '0);
    assign rsp_live = rsp && (drop_cnt_q == '0);
    assign pop      = out_valid && out_ready;

    always_comb begin
        push          = rsp_live;
        flush         = 1'b0;
        halted_d      = halted_q;
        fetch_pc_d    = fetch_pc_q + ADDR_W'(gnt);
        resp_pc_d     = resp_pc_q + ADDR_W'(rsp_live);
        outstanding_d = outstanding_q + CW'(gnt) - CW'(rsp);
        drop_cnt_d    = drop_cnt_q - CW'(rsp && !rsp_live);
        // Everything still in flight after this cycle belongs to the old path.
        if (halt_req) begin
            halted_d   = 1'b1;
            flush      = 1'b1;
            push       = 1'b0;
            drop_cnt_d = outstanding_d;
        end else if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
            resp_pc_d  = redirect_pc;
            flush      = 1'b1;
            push       = 1'b0;
            drop_cnt_d = outstanding_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            halted_q      <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            halted_q      <= halted_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .wdata ({resp_pc_q, imem_rdata}),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    a_no_stray_rvalid: assert property (@(posedge clk) disable iff (rst)
        !(imem_rvalid && (outstanding_q == '0)))
        else $error("fetch_unit: imem_rvalid with no outstanding request");

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && fifo_full && !pop))
        else $error("fetch_unit: push into full buffer");

endmodule
